// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end.
// The FETCH_HALT_EN macro enables halt detection in fetch_controller.
package fetch_pkg;

  localparam int PC_W  = 12;
  localparam int INS_W = 19;

  localparam logic [INS_W-1:0] HALT_WORD = 19'h7FFFF;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } q_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode valid/ready handshake.
// master = fetch side, slave = decode side.
interface fetch_if;
  import fetch_pkg::*;

  logic [INS_W-1:0] InsOut;
  logic [PC_W-1:0]  InsPC;
  logic             InsValid;
  logic             InsReady;

  modport master (
    output InsOut,
    output InsPC,
    output InsValid,
    input  InsReady
  );

  modport slave (
    input  InsOut,
    input  InsPC,
    input  InsValid,
    output InsReady
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, ins}; flush wins over push/pop.
// Head output is forced to zero while empty.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  q_entry_t din,
  output q_entry_t head,
  output logic     full,
  output logic     empty
);

  logic [1:0] cnt;
  q_entry_t   s0;
  q_entry_t   s1;
  logic       do_pop;
  logic       do_push;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : s0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= 2'd0;
    end else begin
      unique case (1'b1)
        do_push && !do_pop: cnt <= cnt + 2'd1;
        do_pop && !do_push: cnt <= cnt - 2'd1;
        default: ;
      endcase
    end
  end

  // s0 is always the head; s1 only meaningful when full
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (do_pop) begin
        if (full) begin
          s0 <= s1;
          if (do_push) s1 <= din;
        end else if (do_push) begin
          s0 <= din;
        end
      end else if (do_push) begin
        if (empty) s0 <= din;
        else       s1 <= din;
      end
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// PC, RUN/HALT FSM and fetch/redirect priority for the front end.
// Define FETCH_HALT_EN to stop fetching on the all-ones word.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PC_W-1:0]  PCout,
  input  logic [INS_W-1:0] InsIn,
  fetch_if.master          dec,
  input  logic             Redirect,
  input  logic [PC_W-1:0]  RedirectPC,
  output logic             Halted
);

  logic [PC_W-1:0] pc;
  fetch_state_t    state;
  logic            pop;
  logic            push;
  logic            full;
  logic            empty;
  logic            is_halt;
  q_entry_t        din;
  q_entry_t        head;

  assign pop  = !empty && dec.InsReady;
  assign push = !Redirect && (state == RUN) && (!full || pop);
  assign din  = '{pc: pc, ins: InsIn};

`ifdef FETCH_HALT_EN
  assign is_halt = (InsIn == HALT_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else if (Redirect) begin
      state <= RUN;
    end else if (push && is_halt) begin
      state <= HALT;
    end
  end
`else
  assign is_halt = 1'b0;
  assign state   = RUN;
`endif

  // halt word is enqueued but the PC parks on its address
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (Redirect) begin
      pc <= RedirectPC;
    end else if (push && !is_halt) begin
      pc <= pc + 1'b1;
    end
  end

  fetch_queue u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (Redirect),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign PCout        = pc;
  assign Halted       = (state == HALT);
  assign dec.InsValid = !empty;
  assign dec.InsOut   = head.ins;
  assign dec.InsPC    = head.pc;

endmodule
